// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: register file, EX/MEM/WB forwarding, load-use interlock, registered EX slot.
// Optional RF_BR_ZERO_EN registers an out_b==0 flag with the slot; otherwise out_b_zero is tied low.
module operand_fetch_stage #(
  parameter int DATA_W   = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  input  logic              use_rs2,
  input  logic [AW-1:0]     rd,
  input  logic              rd_we,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [AW-1:0]     ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_we,
  input  logic [AW-1:0]     mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [AW-1:0]     out_rd,
  output logic              out_we,
  output logic              out_b_zero
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic [AW-1:0]     out_rd_q, out_rd_d;
  logic              out_we_q, out_we_d;

  logic [DATA_W-1:0] a_fwd, b_fwd;
  logic              hazard;
  logic              load_slot;

  // Youngest producer wins; the zero register never matches, so rule 1 shields rules 2-4.
  function automatic logic [DATA_W-1:0] fwd(input logic [AW-1:0] rs, input logic [DATA_W-1:0] rf_val);
    if (rs == ZR)                                         return '0;
    else if (ex_valid && ex_we && !ex_is_load && ex_rd == rs) return ex_result;
    else if (mem_we && mem_rd == rs)                      return mem_result;
    else if (wb_we && wb_rd == rs)                        return wb_data;
    else                                                  return rf_val;
  endfunction

  always_comb begin
    a_fwd = fwd(rs1, regs_q[rs1]);
    b_fwd = fwd(rs2, regs_q[rs2]);
  end

  assign hazard = in_valid && ex_valid && ex_we && ex_is_load && (ex_rd != ZR)
                  && ((ex_rd == rs1) || (use_rs2 && (ex_rd == rs2)));
  assign in_ready  = !hazard && !flush && (!out_valid_q || out_ready);
  assign load_slot = in_valid && in_ready;

  always_comb begin
    regs_d = regs_q;
    if (wb_we && wb_rd != ZR) regs_d[wb_rd] = wb_data;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_rd_d    = out_rd_q;
    out_we_d    = out_we_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_slot) begin
      out_valid_d = 1'b1;
      out_a_d     = a_fwd;
      out_b_d     = b_fwd;
      out_rd_d    = rd;
      out_we_d    = rd_we;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_rd_q    <= out_rd_d;
      out_we_q    <= out_we_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_rd    = out_rd_q;
  assign out_we    = out_we_q;

`ifdef RF_BR_ZERO_EN
  logic b_zero_q, b_zero_d;

  // Loaded together with the operands so EX sees a flag consistent with out_b.
  always_comb begin
    b_zero_d = b_zero_q;
    if (!flush && load_slot) b_zero_d = (b_fwd == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) b_zero_q <= 1'b0;
    else        b_zero_q <= b_zero_d;
  end

  assign out_b_zero = b_zero_q;
`else
  assign out_b_zero = 1'b0;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 0, in_ready, use_rs2 = 0, rd_we = 0, flush = 0;
  logic [4:0]  rs1 = 0, rs2 = 0, rd = 0, ex_rd = 0, mem_rd = 0, wb_rd = 0;
  logic        ex_valid = 0, ex_we = 0, ex_is_load = 0, mem_we = 0, wb_we = 0;
  logic [63:0] ex_result = 0, mem_result = 0, wb_data = 0;
  logic        out_valid, out_ready = 0, out_we, out_b_zero;
  logic [63:0] out_a, out_b;
  logic [4:0]  out_rd;

  int total = 0;
  int bad   = 0;

`ifdef RF_BR_ZERO_EN
  localparam bit ZFLAG = 1'b1;
`else
  localparam bit ZFLAG = 1'b0;
`endif

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .use_rs2(use_rs2), .rd(rd), .rd_we(rd_we), .flush(flush),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_result(ex_result), .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
    .out_we(out_we), .out_b_zero(out_b_zero)
  );

  always #5 clk = ~clk;

  // Reference state: architectural registers and the EX slot contents.
  logic [63:0] m_regs [32];
  logic        m_ov, m_we, m_bz;
  logic [63:0] m_a, m_b;
  logic [4:0]  m_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Producers listed youngest first; the first one naming rs supplies the value.
  function automatic logic [63:0] m_opnd(input logic [4:0] rs);
    logic        act [3];
    logic [4:0]  dst [3];
    logic [63:0] val [3];
    if (rs == 5'd31) return 64'd0;
    act = '{ex_valid && ex_we && !ex_is_load, mem_we, wb_we};
    dst = '{ex_rd, mem_rd, wb_rd};
    val = '{ex_result, mem_result, wb_data};
    for (int i = 0; i < 3; i++)
      if (act[i] && dst[i] == rs) return val[i];
    return m_regs[rs];
  endfunction

  task automatic step();
    logic        hz, rdy;
    logic [63:0] na, nb;
    #1;
    hz  = in_valid && ex_valid && ex_we && ex_is_load && ex_rd != 5'd31 &&
          (ex_rd == rs1 || (use_rs2 && ex_rd == rs2));
    rdy = !hz && !flush && (!m_ov || out_ready);
    if (rst_n) chk("in_ready", in_ready, rdy);
    na = m_opnd(rs1);
    nb = m_opnd(rs2);
    @(posedge clk);
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 64'd0;
      m_ov = 0; m_a = 0; m_b = 0; m_rd = 0; m_we = 0; m_bz = 0;
    end else begin
      if (flush) m_ov = 0;
      else if (in_valid && rdy) begin
        m_ov = 1; m_a = na; m_b = nb; m_rd = rd; m_we = rd_we;
        m_bz = ZFLAG && (nb == 64'd0);
      end else if (out_ready) m_ov = 0;
      if (wb_we && wb_rd != 5'd31) m_regs[wb_rd] = wb_data;
    end
    #1;
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_a", out_a, m_a);
      chk("out_b", out_b, m_b);
      chk("out_rd", out_rd, m_rd);
      chk("out_we", out_we, m_we);
      chk("out_b_zero", out_b_zero, m_bz);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; use_rs2 = 0; rd_we = 0; flush = 0; out_ready = 1;
    rs1 = 0; rs2 = 0; rd = 0;
    ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
    mem_we = 0; mem_rd = 0; mem_result = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  function automatic logic [4:0] r_idx();
    return ($urandom_range(0, 9) > 7) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [63:0] r_dat();
    return ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
  endfunction

  initial begin
    foreach (m_regs[i]) m_regs[i] = 64'd0;
    m_ov = 0; m_a = 0; m_b = 0; m_rd = 0; m_we = 0; m_bz = 0;

    // Reset
    idle_inputs();
    rst_n = 0;
    step(); step();
    chk("rst_valid", out_valid, 64'd0);
    chk("rst_a", out_a, 64'd0);
    chk("rst_b", out_b, 64'd0);
    rst_n = 1;
    in_valid = 1; rs1 = 5;
    step();
    chk("x5_after_rst", out_a, 64'd0);

    // EX forward
    ex_valid = 1; ex_we = 1; ex_rd = 3; ex_result = 64'h1234; rs1 = 3; rd = 9; rd_we = 1;
    step();
    chk("ex_fwd_a", out_a, 64'h1234);
    chk("ex_fwd_valid", out_valid, 64'd1);

    // Priority EX > MEM > WB
    idle_inputs();
    in_valid = 1; rs2 = 4; use_rs2 = 1;
    ex_valid = 1; ex_we = 1; ex_rd = 4; ex_result = 64'hA;
    mem_we = 1; mem_rd = 4; mem_result = 64'hB;
    wb_we = 1; wb_rd = 4; wb_data = 64'hC;
    step();
    chk("prio_ex", out_b, 64'hA);
    ex_valid = 0;
    step();
    chk("prio_mem", out_b, 64'hB);

    // Load-use stall then MEM forward
    idle_inputs();
    in_valid = 1; rs1 = 7; ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rd = 7;
    #1 chk("lu_stall_rdy", in_ready, 64'd0);
    step();
    chk("lu_bubble", out_valid, 64'd0);
    ex_valid = 0; ex_is_load = 0; mem_we = 1; mem_rd = 7; mem_result = 64'h99;
    step();
    chk("lu_mem_a", out_a, 64'h99);
    idle_inputs();
    in_valid = 1; rs1 = 1; rs2 = 7; use_rs2 = 0;
    ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rd = 7;
    #1 chk("imm_no_stall", in_ready, 64'd1);
    step();

    // XZR and same-cycle WB bypass
    idle_inputs();
    in_valid = 1; rs1 = 31; wb_we = 1; wb_rd = 31; wb_data = 64'hFF;
    step();
    chk("xzr_a", out_a, 64'd0);
    rs1 = 2; wb_rd = 2; wb_data = 64'h55;
    step();
    chk("wb_bypass_a", out_a, 64'h55);

    // Backpressure then flush
    idle_inputs();
    in_valid = 1; rs1 = 2;
    step();
    out_ready = 0; rs1 = 3;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_rdy", in_ready, 64'd0);
      step();
      chk("bp_hold_a", out_a, 64'h55);
    end
    flush = 1;
    step();
    chk("flush_valid", out_valid, 64'd0);
    flush = 0; out_ready = 1; rs2 = 31; use_rs2 = 1;
    step();
    chk("b_zero_flag", out_b_zero, 64'(ZFLAG));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      in_valid   = $urandom_range(0, 3) != 0;
      rs1 = r_idx(); rs2 = r_idx(); rd = r_idx();
      use_rs2    = $urandom_range(0, 1);
      rd_we      = $urandom_range(0, 1);
      flush      = ($urandom_range(0, 9) == 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      ex_valid   = $urandom_range(0, 1);
      ex_we      = $urandom_range(0, 1);
      ex_is_load = ($urandom_range(0, 3) == 0);
      ex_rd = r_idx(); ex_result = r_dat();
      mem_we = $urandom_range(0, 1); mem_rd = r_idx(); mem_result = r_dat();
      wb_we  = $urandom_range(0, 1); wb_rd  = r_idx(); wb_data    = r_dat();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
